// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU mux.
// Optional ALU_ARBITER_FLAGS_EN adds registered zero/negative flags on rsp_flags.
module alu_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [3:0]   req0_op,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [3:0]   req1_op,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   output logic [3:0]   alu_sel,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   input  logic [N-1:0] alu_result,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_result,
`ifdef ALU_ARBITER_FLAGS_EN
   output logic [1:0]   rsp_flags,
`endif
   output logic         rsp_err
);

   localparam int unsigned OP_W = 4;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state_q, state_d;
   logic [OP_W-1:0] op_q, op_d;
   logic [N-1:0]    a_q, a_d, b_q, b_d;
   logic [N-1:0]    res_q, res_d;
   logic            valid_q, valid_d;
   logic            id_q, id_d;
   logic            err_q, err_d;
   logic            last_q, last_d;
   logic [1:0]      flags_q, flags_d;
   logic            grant1;
   logic [OP_W-1:0] win_op;

   // Next-state, latch updates and the acceptance handshake.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      valid_d    = valid_q;
      id_d       = id_q;
      err_d      = err_q;
      last_d     = last_q;
      flags_d    = flags_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      grant1     = req1_valid && (!req0_valid || !last_q);
      win_op     = grant1 ? req1_op : req0_op;

      case (state_q)
         IDLE: begin
            if (!rst && (req0_valid || req1_valid)) begin
               req0_ready = !grant1;
               req1_ready = grant1;
               a_d        = grant1 ? req1_a : req0_a;
               b_d        = grant1 ? req1_b : req0_b;
               last_d     = grant1;
               id_d       = grant1;
               // Illegal opcodes never reach alu_sel; they answer immediately.
               if (win_op[3:2] == 2'b00) begin
                  op_d    = win_op;
                  state_d = EXEC;
               end else begin
                  res_d   = '0;
                  err_d   = 1'b1;
                  flags_d = 2'b00;
                  valid_d = 1'b1;
                  state_d = RESP;
               end
            end
         end
         EXEC: begin
            res_d   = alu_result;
            err_d   = 1'b0;
            flags_d = {alu_result[N-1], (alu_result == '0)};
            valid_d = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         valid_q <= 1'b0;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
         last_q  <= 1'b1;
         flags_q <= 2'b00;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         valid_q <= valid_d;
         id_q    <= id_d;
         err_q   <= err_d;
         last_q  <= last_d;
         flags_q <= flags_d;
      end
   end

   assign alu_sel    = op_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign rsp_valid  = valid_q;
   assign rsp_id     = id_q;
   assign rsp_result = res_q;
   assign rsp_err    = err_q;
`ifdef ALU_ARBITER_FLAGS_EN
   assign rsp_flags  = flags_q;
`else
   logic unused_flags;
   assign unused_flags = ^flags_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// against a transaction-level model; the bench also plays the shared ALU.
module tb_alu_arbiter;

   localparam int unsigned N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req1_valid, req0_ready, req1_ready;
   logic [3:0]   req0_op, req1_op, alu_sel;
   logic [N-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [N-1:0] rsp_result;
`ifdef ALU_ARBITER_FLAGS_EN
   logic [1:0]   rsp_flags;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result),
`ifdef ALU_ARBITER_FLAGS_EN
      .rsp_flags(rsp_flags),
`endif
      .rsp_err(rsp_err)
   );

   function automatic logic [N-1:0] ref_alu(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         default: return '0;
      endcase
   endfunction

   // Shared ALU result mux.
   always_comb alu_result = ref_alu(alu_sel, alu_a, alu_b);

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      req0_op = 4'd0; req1_op = 4'd0;
      req0_a = 4'd1; req0_b = 4'd1; req1_a = 4'd1; req1_b = 4'd1;
      repeat (2) @(negedge clk);
      #1;
      total_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); else pass_cnt++;
      total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else pass_cnt++;
      total_cnt++; if (rsp_result !== '0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) $display("FAIL reset_rsp_fields got=%h/%b/%b exp=0/0/0", rsp_result, rsp_id, rsp_err); else pass_cnt++;
      total_cnt++; if (alu_sel !== 4'd0 || alu_a !== '0 || alu_b !== '0) $display("FAIL reset_alu got=%h/%h/%h exp=0/0/0", alu_sel, alu_a, alu_b); else pass_cnt++;
`ifdef ALU_ARBITER_FLAGS_EN
      total_cnt++; if (rsp_flags !== 2'b00) $display("FAIL reset_flags got=%b exp=00", rsp_flags); else pass_cnt++;
`endif
      @(negedge clk);
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      req0_valid = 1'b1; req0_op = 4'd0; req0_a = 4'd3; req0_b = 4'd4; rsp_ready = 1'b1;
      #1;
      total_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL basic_grant got=%b%b exp=01", req1_ready, req0_ready); else pass_cnt++;
      @(negedge clk); req0_valid = 1'b0; #1;
      total_cnt++; if (alu_sel !== 4'd0 || alu_a !== 4'd3 || alu_b !== 4'd4) $display("FAIL basic_alu got=%h/%h/%h exp=0/3/4", alu_sel, alu_a, alu_b); else pass_cnt++;
      total_cnt++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b0) $display("FAIL basic_exec got=%b/%b exp=0/0", rsp_valid, req0_ready); else pass_cnt++;
      @(negedge clk); #1;
      total_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 4'd7 || rsp_err !== 1'b0) $display("FAIL basic_rsp got=%b/%b/%h/%b exp=1/0/7/0", rsp_valid, rsp_id, rsp_result, rsp_err); else pass_cnt++;
      @(negedge clk); #1;
      total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL basic_rsp_done got=%b exp=0", rsp_valid); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      logic got;
      int c;
      do_reset();
      req0_valid = 1'b1; req0_op = 4'd1; req0_a = 4'd5; req0_b = 4'd2;
      req1_valid = 1'b1; req1_op = 4'd2; req1_a = 4'hC; req1_b = 4'hA;
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         c = 0;
         while (!(req0_ready || req1_ready) && c < 6) begin @(negedge clk); #1; c++; end
         got = req1_ready;
         total_cnt++; if (c >= 6 || (req0_ready && req1_ready) || got !== 1'(k % 2)) $display("FAIL rr_grant%0d got=%b%b exp_id=%0d", k, req1_ready, req0_ready, k % 2); else pass_cnt++;
         @(negedge clk); #1;
         c = 0;
         while (!rsp_valid && c < 6) begin @(negedge clk); #1; c++; end
         total_cnt++; if (c >= 6 || rsp_id !== got || rsp_result !== (got ? 4'd8 : 4'd3)) $display("FAIL rr_rsp%0d got=%b/%h exp=%b/%h", k, rsp_id, rsp_result, got, got ? 4'd8 : 4'd3); else pass_cnt++;
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_illegal();
      do_reset();
      req0_valid = 1'b1; req0_op = 4'd3; req0_a = 4'd1; req0_b = 4'd2; rsp_ready = 1'b1;
      @(negedge clk); req0_valid = 1'b0;
      repeat (2) @(negedge clk);
      req1_valid = 1'b1; req1_op = 4'b0101; req1_a = 4'd7; req1_b = 4'd7;
      #1;
      total_cnt++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) $display("FAIL illegal_grant got=%b%b exp=10", req1_ready, req0_ready); else pass_cnt++;
      @(negedge clk); req1_valid = 1'b0; #1;
      total_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== '0 || rsp_id !== 1'b1) $display("FAIL illegal_rsp got=%b/%b/%h/%b exp=1/1/0/1", rsp_valid, rsp_err, rsp_result, rsp_id); else pass_cnt++;
      total_cnt++; if (alu_sel !== 4'd3) $display("FAIL illegal_sel got=%h exp=3", alu_sel); else pass_cnt++;
`ifdef ALU_ARBITER_FLAGS_EN
      total_cnt++; if (rsp_flags !== 2'b00) $display("FAIL illegal_flags got=%b exp=00", rsp_flags); else pass_cnt++;
`endif
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      do_reset();
      req0_valid = 1'b1; req0_op = 4'd0; req0_a = 4'd1; req0_b = 4'd1; rsp_ready = 1'b0;
      req1_op = 4'd0; req1_a = 4'd2; req1_b = 4'd2;
      @(negedge clk); req1_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         #1;
         total_cnt++; if (rsp_valid !== 1'b1 || rsp_result !== 4'd2 || rsp_id !== 1'b0 || rsp_err !== 1'b0) $display("FAIL bp_hold%0d got=%b/%h/%b/%b exp=1/2/0/0", i, rsp_valid, rsp_result, rsp_id, rsp_err); else pass_cnt++;
         total_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL bp_ready%0d got=%b%b exp=00", i, req1_ready, req0_ready); else pass_cnt++;
         @(negedge clk);
      end
      rsp_ready = 1'b1; #1;
      total_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL bp_release_ready got=%b%b exp=00", req1_ready, req0_ready); else pass_cnt++;
      @(negedge clk); rsp_ready = 1'b0; #1;
      total_cnt++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL bp_next_grant got=%b%b/%b exp=10/0", req1_ready, req0_ready, rsp_valid); else pass_cnt++;
      @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req0_valid = 1'b1; req0_op = 4'd0; req0_a = 4'd1; req0_b = 4'd1; rsp_ready = 1'b1;
      req1_op = 4'd0; req1_a = 4'd1; req1_b = 4'd1;
      #1;
      total_cnt++; if (req0_ready !== 1'b1) $display("FAIL mid_first_grant got=%b exp=1", req0_ready); else pass_cnt++;
      @(negedge clk); rst = 1'b1; req1_valid = 1'b1; #1;
      total_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL mid_rst_ready got=%b%b exp=00", req1_ready, req0_ready); else pass_cnt++;
      @(negedge clk); rst = 1'b0; #1;
      total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL mid_no_rsp got=%b exp=0", rsp_valid); else pass_cnt++;
      total_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL mid_contention got=%b%b exp=01", req1_ready, req0_ready); else pass_cnt++;
      @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

`ifdef ALU_ARBITER_FLAGS_EN
   task automatic test_flags();
      do_reset();
      req0_valid = 1'b1; req0_op = 4'd1; req0_a = 4'd3; req0_b = 4'd3; rsp_ready = 1'b1;
      @(negedge clk); req0_valid = 1'b0;
      @(negedge clk); #1;
      total_cnt++; if (rsp_valid !== 1'b1 || rsp_result !== 4'd0 || rsp_flags !== 2'b01) $display("FAIL flags_zero got=%b/%h/%b exp=1/0/01", rsp_valid, rsp_result, rsp_flags); else pass_cnt++;
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd5;
      @(negedge clk); req0_valid = 1'b0;
      @(negedge clk); #1;
      total_cnt++; if (rsp_valid !== 1'b1 || rsp_result !== 4'hD || rsp_flags !== 2'b10) $display("FAIL flags_neg got=%b/%h/%b exp=1/d/10", rsp_valid, rsp_result, rsp_flags); else pass_cnt++;
      @(negedge clk);
   endtask
`endif

   // Transaction-level model: one operation in flight, round-robin on contention.
   task automatic test_random();
      bit           busy = 1'b0;
      int           wait_cyc = 0;
      bit           last = 1'b1;
      logic [3:0]   exp_sel = 4'd0;
      bit           exp_id = 1'b0, exp_err = 1'b0;
      logic [N-1:0] exp_res = '0;
      bit           g1, acc;
      logic [3:0]   wop;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
         req0_op = 4'($urandom_range(0, 5)); req1_op = 4'($urandom_range(0, 5));
         req0_a = N'($urandom); req0_b = N'($urandom); req1_a = N'($urandom); req1_b = N'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         acc = !busy && (req0_valid || req1_valid);
         g1 = req1_valid && req0_valid ? !last : req1_valid;
         total_cnt++; if (req0_ready !== (acc && !g1) || req1_ready !== (acc && g1)) $display("FAIL rnd_ready c%0d got=%b%b exp=%b%b", cyc, req1_ready, req0_ready, acc && g1, acc && !g1); else pass_cnt++;
         total_cnt++; if (rsp_valid !== (busy && wait_cyc == 0)) $display("FAIL rnd_valid c%0d got=%b exp=%b", cyc, rsp_valid, busy && wait_cyc == 0); else pass_cnt++;
         total_cnt++; if (alu_sel !== exp_sel) $display("FAIL rnd_sel c%0d got=%h exp=%h", cyc, alu_sel, exp_sel); else pass_cnt++;
         if (busy && wait_cyc == 0) begin
            total_cnt++; if (rsp_id !== exp_id || rsp_result !== exp_res || rsp_err !== exp_err) $display("FAIL rnd_rsp c%0d got=%b/%h/%b exp=%b/%h/%b", cyc, rsp_id, rsp_result, rsp_err, exp_id, exp_res, exp_err); else pass_cnt++;
`ifdef ALU_ARBITER_FLAGS_EN
            total_cnt++; if (rsp_flags !== (exp_err ? 2'b00 : {exp_res[N-1], exp_res == '0})) $display("FAIL rnd_flags c%0d got=%b res=%h err=%b", cyc, rsp_flags, exp_res, exp_err); else pass_cnt++;
`endif
         end
         if (busy) begin
            if (wait_cyc == 0) begin
               if (rsp_ready) busy = 1'b0;
            end else wait_cyc--;
         end else if (acc) begin
            wop = g1 ? req1_op : req0_op;
            busy = 1'b1; last = g1; exp_id = g1;
            exp_err = (wop > 4'd3);
            wait_cyc = exp_err ? 0 : 1;
            exp_res = exp_err ? '0 : ref_alu(wop, g1 ? req1_a : req0_a, g1 ? req1_b : req0_b);
            if (!exp_err) exp_sel = wop;
         end
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_illegal();
      test_backpressure();
      test_reset_mid();
`ifdef ALU_ARBITER_FLAGS_EN
      test_flags();
`endif
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
